mod_counter_arbiter: RTL
========================

// Module: mod_counter_arbiter
// PURPOSE
//   Shares one mod-M up-counter between N_REQ requesters. Arbitrates with
//   round-robin priority, latches the winner's terminal count and runs the
//   counter 0..term. It then pulses done to the owner and releases the counter.
//   Sits between timing/divider consumers and the shared counter datapath.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   CNT_W  4  counter / terminal-count width in bits
// PORTS
//   clk_i    in   1            clock, rising edge
//   rst_n_i  in   1            asynchronous active-low reset
//   req_i    in   N_REQ        per-requester request level; hold until done or abort
//   term_i   in   N_REQ*CNT_W  per-requester terminal count; slice r = [r*CNT_W +: CNT_W]
//   gnt_o    out  N_REQ        one-hot grant; high for every RUN cycle of the owner
//   count_o  out  CNT_W        shared counter value
//   done_o   out  N_REQ        one-hot, one-cycle pulse: owner's count completed
//   busy_o   out  1            high in RUN and DONE
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE; gnt_o=0, done_o=0, count_o=0, busy_o=0.
//   - RR pointer=0, so requester 0 has highest priority first.
// - FSM states: IDLE, RUN, DONE.
// - IDLE:
//   - If any req_i is set, pick the first set bit scanning up from the RR pointer, with wrap.
//   - Latch owner and term=term_i[owner]; load count_o=0; go to RUN.
//   - With no request, stay in IDLE.
// - RUN:
//   - gnt_o[owner]=1.
//   - If req_i[owner]=0 (abort): go to IDLE next; count_o returns to 0 and gnt_o drops.
//     No done_o pulse. RR pointer = owner+1.
//   - Else if count_o >= term: go to DONE; count_o returns to 0.
//   - Else count_o increments by 1.
// - DONE:
//   - done_o[owner]=1 for exactly one cycle; gnt_o=0.
//   - RR pointer = owner+1 mod N_REQ; go to IDLE.
// - Latency:
//   - req seen in IDLE at edge k: gnt_o and count_o=0 appear after edge k+1.
//   - count_o=term after edge k+1+term; done_o after edge k+2+term.
//   - Grant length is term+1 cycles.
// - term=0: a single RUN cycle with count_o=0, then DONE.
// - term_i changes during RUN are ignored; the latched value applies.
// - Requests from non-owners during RUN/DONE are held off. They are arbitrated in
//   the next IDLE cycle, so the minimum gap between grants is 2 cycles (DONE, IDLE).
// - If the owner keeps req high after done, it competes again at lowest priority.
// - count_o never exceeds term, and wraps only via the return to 0.
//   Width arithmetic is modulo 2^CNT_W; term=2^CNT_W-1 is legal.
// - Reset asserted mid-RUN: all outputs clear immediately, with no done pulse.
// - gnt_o and done_o are always at most one-hot and never high in the same cycle.
// TESTING
// 1. Single request: req_i=0001, term0=9.
//    -> gnt_o=0001 for 10 cycles, count_o 0..9, then done_o=0001 for 1 cycle, busy_o low after.
// 2. Round robin: req_i=1111 held, all terms=2.
//    -> grant order 0,1,2,3,0; each grant 3 cycles; a 2-cycle gap between grants.
// 3. Abort: req0 term=9, drop req_i[0] when count_o=4.
//    -> gnt_o=0 and count_o=0 next cycle; done_o stays 0; RR pointer moves to 1.
// 4. term=0 and term=15 (CNT_W=4).
//    -> grant lasts 1 cycle and 16 cycles respectively; count_o never exceeds 15.
// 5. Reset asserted asynchronously mid-RUN at count_o=5.
//    -> outputs 0 without waiting for a clock; after release, requester 0 wins first.
// 6. term_i[owner] changed from 9 to 3 during RUN.
//    -> count still runs to 9; check that one-hot and mutual-exclusion assertions hold.

Source files
------------

// File: rtl/mod_counter_arbiter.sv
// mod_counter_arbiter: round-robin arbiter sharing one mod-M up-counter between requesters
module mod_counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CNT_W-1:0] term_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [CNT_W-1:0]       count_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick, nxt;
    logic [CNT_W-1:0] term_q, term_d, count_q, count_d;
    logic [N_REQ-1:0] owner_oh;
    logic found;
    always_comb begin
        pick = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % N_REQ]) begin
                found = 1'b1;
                pick = IW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end
    assign nxt = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IW'(1);
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        term_d = term_q;
        count_d = count_q;
        ptr_d = ptr_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = RUN;
                owner_d = pick;
                term_d = term_i[int'(pick)*CNT_W +: CNT_W];
                count_d = '0;
            end
            RUN: if (!req_i[owner_q]) begin
                state_d = IDLE;
                count_d = '0;
                ptr_d = nxt;
            end else if (count_q >= term_q) begin
                state_d = DONE;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                ptr_d = nxt;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            term_q <= '0;
            count_q <= '0;
            ptr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            term_q <= term_d;
            count_q <= count_d;
            ptr_q <= ptr_d;
        end
    end
    // Outputs decode straight from state so an async reset clears them at once.
    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign gnt_o = (state_q == RUN) ? owner_oh : '0;
    assign done_o = (state_q == DONE) ? owner_oh : '0;
    assign busy_o = (state_q != IDLE);
    assign count_o = count_q;
endmodule
